// File: rtl/usb_uart_tx_arbiter_pkg.sv
// Shared definitions for the usb_uart transmit arbiter: FSM state encodings,
// the default end-of-line byte and a helper that sizes the hold timer.
package usb_uart_tx_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam logic [7:0] EOL_DEFAULT = 8'h0A;

  // Width that holds 0..limit-1; a degenerate limit still gets one bit.
  function automatic int timer_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/usb_uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// searching ptr+1, ptr+2, ... (mod N), plus a flag that any request is set.
module rr_pick #(
  parameter int  N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any
);

  logic [W-1:0] cand_idx [N];
  logic [N-1:0] cand_req;

  // Candidate gi is the requester gi+1 places after the pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    localparam int OFS = gi + 1;
    assign cand_idx[gi] = W'((32'(ptr) + OFS) % N);
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  always_comb begin
    any   = |cand_req;
    grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        grant = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/usb_uart_tx_arbiter.sv
// Round-robin arbiter sharing the usb_uart byte transmit port; an owner keeps
// the port until it sends the end-of-line byte or idles out of HOLD.
module usb_uart_tx_arbiter
  import usb_uart_tx_arbiter_pkg::*;
#(
  parameter int         NUM_REQ      = 2,
  parameter logic [7:0] EOL_BYTE     = EOL_DEFAULT,
  parameter int         HOLD_TIMEOUT = 4800,
  localparam int        GW           = $clog2(NUM_REQ)
) (
  input  logic                 clk_48mhz,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_we,
  output logic [7:0]           uart_di,
  input  logic                 uart_wait,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  localparam int             TW         = timer_width(HOLD_TIMEOUT);
  localparam logic [TW-1:0]  TIMER_LAST = TW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

  state_t        state_reg,    state_next;
  logic [GW-1:0] rr_ptr_reg,   rr_ptr_next;
  logic [TW-1:0] timer_reg,    timer_next;
  logic          uart_we_reg,  uart_we_next;
  logic [7:0]    uart_di_reg,  uart_di_next;
  logic [GW-1:0] grant_id_reg, grant_id_next;

  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic          take;
  logic [GW-1:0] take_idx;
  logic [7:0]    take_byte;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (pick_idx),
    .any   (pick_any)
  );

  // A byte is taken only in IDLE (round-robin winner) or HOLD (owner only);
  // never in SEND, so uart_di cannot change while uart_we is high.
  always_comb begin
    take     = 1'b0;
    take_idx = grant_id_reg;
    case (state_reg)
      ST_IDLE: begin
        take     = pick_any;
        take_idx = pick_idx;
      end
      ST_HOLD: take = req_valid[grant_id_reg];
      default: ;
    endcase
    req_ready = '0;
    if (take) begin
      req_ready[take_idx] = 1'b1;
    end
    take_byte = req_data[{take_idx, 3'b000} +: 8];
  end

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    timer_next    = timer_reg;
    uart_we_next  = uart_we_reg;
    uart_di_next  = uart_di_reg;
    grant_id_next = grant_id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (take) begin
          uart_di_next  = take_byte;
          uart_we_next  = 1'b1;
          grant_id_next = take_idx;
          state_next    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!uart_wait) begin
          uart_we_next = 1'b0;
          if (uart_di_reg == EOL_BYTE || HOLD_TIMEOUT == 0) begin
            rr_ptr_next = grant_id_reg;
            state_next  = ST_IDLE;
          end else begin
            timer_next = '0;
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // An owner byte arriving on the expiry cycle wins over the release.
        if (take) begin
          uart_di_next = take_byte;
          uart_we_next = 1'b1;
          state_next   = ST_SEND;
        end else if (timer_reg == TIMER_LAST) begin
          rr_ptr_next = grant_id_reg;
          state_next  = ST_IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= GW'(NUM_REQ - 1);
      timer_reg    <= '0;
      uart_we_reg  <= 1'b0;
      uart_di_reg  <= 8'h00;
      grant_id_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      timer_reg    <= timer_next;
      uart_we_reg  <= uart_we_next;
      uart_di_reg  <= uart_di_next;
      grant_id_reg <= grant_id_next;
    end
  end

  assign uart_we  = uart_we_reg;
  assign uart_di  = uart_di_reg;
  assign grant_id = grant_id_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule
